// File: rtl/ss_matmul.sv
// ss_matmul: streaming square-matrix multiplier (N = 2 or 4).
//
// Purpose:
//   Receives signed X then W, row-major, one element per cycle. Returns
//   C = X*W row-major, one element per cycle, sign-extended to OUT_W bits.
//   Each output element is formed in a single cycle by MAX_N parallel
//   multipliers.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    high while input elements are presented
//   matrix      input element (signed); all of X first, then all of W
//   matrix_size sampled on the first in_valid cycle only: 0 -> N=2, 1 -> N=4
//   out_valid   high while out_value carries a result element
//   out_value   result element (signed); forced to 0 while out_valid is low
//   dbg_state   current FSM state, for observation
//
// Valid semantics: there is no back-pressure. in_valid marks each cycle that
// carries an input element, and a pattern ends on the first cycle in_valid is
// low. out_valid marks each cycle that carries one C element. in_valid and
// out_valid are never high together.
module ss_matmul #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 40,
  parameter int MAX_N  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] matrix,
  input  logic              matrix_size,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_value,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = MAX_N * MAX_N;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  state_t            state_q;
  logic              n4_q;
  logic [5:0]        idx_q;   // input element index while loading, output index afterwards
  logic [DATA_W-1:0] x_q [DEPTH];
  logic [DATA_W-1:0] w_q [DEPTH];

  logic [5:0]        nsq;      // N*N
  logic [5:0]        load_lim; // 2*N*N
  logic [3:0]        w_addr;
  logic [OUT_W-1:0]  elem_d;

  assign nsq      = n4_q ? 6'd16 : 6'd4;
  assign load_lim = n4_q ? 6'd32 : 6'd8;
  // W element k lives at k - N*N. For N=4 that is the low 4 bits of the
  // index (16..31); for N=2 it is the low 2 bits (4..7).
  assign w_addr   = n4_q ? idx_q[3:0] : {2'b00, idx_q[1:0]};
  assign dbg_state = state_q;

  // One C element per cycle: C[i][j] = sum over k < N of X[i][k] * W[k][j].
  // For N=2 only entries 0..3 are addressed and terms k >= 2 are dropped, so
  // stale upper storage cannot leak into the result.
  logic [1:0]               elem_i, elem_j, kk;
  logic [3:0]               xa, wa;
  logic signed [2*DATA_W-1:0] prod;
  logic [2*DATA_W+1:0]      acc;

  always_comb begin
    elem_i = n4_q ? idx_q[3:2] : {1'b0, idx_q[1]};
    elem_j = n4_q ? idx_q[1:0] : {1'b0, idx_q[0]};
    acc    = '0;
    kk     = '0;
    xa     = '0;
    wa     = '0;
    prod   = '0;
    for (int k = 0; k < MAX_N; k++) begin
      kk   = 2'(k);
      xa   = n4_q ? {elem_i, kk} : {2'b00, elem_i[0], kk[0]};
      wa   = n4_q ? {kk, elem_j} : {2'b00, kk[0], elem_j[0]};
      prod = $signed(x_q[xa]) * $signed(w_q[wa]);
      if (n4_q || k < 2) begin
        acc = acc + {{2{prod[2*DATA_W-1]}}, prod};
      end
    end
    elem_d = {{(OUT_W-2*DATA_W-2){acc[2*DATA_W+1]}}, acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n4_q      <= 1'b0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      for (int a = 0; a < DEPTH; a++) begin
        x_q[a] <= '0;
        w_q[a] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          out_valid <= 1'b0;
          out_value <= '0;
          if (in_valid) begin
            n4_q    <= matrix_size;
            x_q[0]  <= matrix;
            idx_q   <= 6'd1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            // Elements beyond 2*N*N are ignored rather than wrapping.
            if (idx_q < load_lim) begin
              if (idx_q < nsq) x_q[idx_q[3:0]] <= matrix;
              else             w_q[w_addr]     <= matrix;
              idx_q <= idx_q + 6'd1;
            end
          end else begin
            idx_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          // idx_q is 0 here, so elem_d is C[0][0].
          out_valid <= 1'b1;
          out_value <= elem_d;
          idx_q     <= 6'd1;
          state_q   <= OUT;
        end
        OUT: begin
          if (idx_q == nsq) begin
            out_valid <= 1'b0;
            out_value <= '0;
            idx_q     <= '0;
            state_q   <= IDLE;
          end else begin
            out_value <= elem_d;
            idx_q     <= idx_q + 6'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_matmul.sv
module tb_ss_matmul;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] matrix;
  logic        matrix_size;
  logic        out_valid;
  logic [39:0] out_value;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  int xm [16];
  int wm [16];
  logic [39:0] exp_q[$];

  ss_matmul dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .matrix      (matrix),
    .matrix_size (matrix_size),
    .out_valid   (out_valid),
    .out_value   (out_value),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "watchdog");
  end

  // Per-cycle protocol monitor.
  always @(negedge clk) begin
    checks++;
    if (in_valid && out_valid) begin
      failures++;
      $display("FAIL overlap: in_valid=1 out_valid=1, required never both high");
    end
    if (!out_valid && out_value !== 40'd0) begin
      failures++;
      $display("FAIL idle_zero: out_value=%h while out_valid=0, required 0", out_value);
    end
  end

  // ---------------- reference model ----------------
  task automatic build_expected(input int n);
    longint s;
    logic [63:0] sv;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += longint'(xm[i*n+k]) * longint'(wm[k*n+j]);
        sv = s;
        exp_q.push_back(sv[39:0]);
      end
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_element(input int v, input logic first, input logic sz);
    @(posedge clk); #1;
    in_valid    = 1'b1;
    matrix      = 16'(v);
    matrix_size = first ? sz : 1'($urandom_range(0, 1));
  endtask

  task automatic load_pattern(input int n);
    for (int k = 0; k < 2*n*n; k++)
      drive_element(k < n*n ? xm[k] : wm[k-n*n], k == 0, n == 4);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    matrix      = 16'($urandom);
    matrix_size = 1'($urandom_range(0, 1));
  endtask

  // Wait for outputs, compare against exp_q, confirm count and drop.
  task automatic collect(input int n, input string name);
    int lat;
    logic [39:0] e;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 12) begin
      lat++;
      @(negedge clk);
    end
    checks++;
    if (!out_valid || lat > 10) begin
      failures++;
      $display("FAIL %s_latency: waited %0d cycles valid=%0b, required valid within 10", name, lat, out_valid);
      exp_q.delete();
      return;
    end
    for (int c = 0; c < n*n; c++) begin
      if (c != 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_value !== e) begin
        failures++;
        $display("FAIL %s_elem%0d: valid=%0b value=%h, required valid=1 value=%h",
                 name, c, out_valid, out_value, e);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_count: out_valid still high after %0d outputs, required low", name, n*n);
    end
  endtask

  task automatic run(input int n, input string name);
    build_expected(n);
    load_pattern(n);
    collect(n, name);
  endtask

  task automatic expect_silent(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL %s: %0d valid cycles after reset, required 0", name, seen);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; matrix = '0; matrix_size = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_value !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b value=%h, required 0/0", out_valid, out_value);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_small_n2();
    int xs[4] = '{1, 2, 3, 4};
    int ws[4] = '{5, 6, 7, 8};
    for (int k = 0; k < 4; k++) begin xm[k] = xs[k]; wm[k] = ws[k]; end
    build_expected(2);
    checks++;
    if (exp_q[0] !== 40'd19 || exp_q[3] !== 40'd50) begin
      failures++;
      $display("FAIL model_small: %0d,%0d, required 19,50", exp_q[0], exp_q[3]);
    end
    load_pattern(2);
    collect(2, "small_n2");
  endtask

  task automatic test_identity_n4();
    for (int k = 0; k < 16; k++) begin
      xm[k] = (k / 4 == k % 4) ? 1 : 0;
      wm[k] = k + 1;
    end
    run(4, "identity_n4");
  endtask

  task automatic test_extremes();
    int xs[4] = '{-1, 2, 0, 1};
    int ws[4] = '{3, 0, 0, -4};
    for (int k = 0; k < 4; k++) begin xm[k] = -32768; wm[k] = -32768; end
    run(2, "min_n2");
    for (int k = 0; k < 4; k++) begin xm[k] = xs[k]; wm[k] = ws[k]; end
    run(2, "signed_n2");
    for (int k = 0; k < 16; k++) begin xm[k] = -32768; wm[k] = -32768; end
    build_expected(4);
    checks++;
    if (exp_q[0] !== 40'h0100000000) begin
      failures++;
      $display("FAIL model_min_n4: %h, required 0100000000", exp_q[0]);
    end
    load_pattern(4);
    collect(4, "min_n4");
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 8; p++) begin
      n = ($urandom_range(0, 1) == 1) ? 4 : 2;
      for (int k = 0; k < 16; k++) begin xm[k] = rnd16(); wm[k] = rnd16(); end
      run(n, "random");
    end
  endtask

  task automatic test_back_to_back();
    int sizes[3] = '{4, 2, 4};
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 16; k++) begin xm[k] = rnd16(); wm[k] = rnd16(); end
      run(sizes[p], "b2b");
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    // Abort during N=4 loading.
    for (int k = 0; k < 16; k++) begin xm[k] = rnd16(); wm[k] = rnd16(); end
    for (int k = 0; k < 10; k++) drive_element(xm[k], k == 0, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_value !== 40'd0) begin
      failures++;
      $display("FAIL reset_mid_load: valid=%0b value=%h, required 0/0", out_valid, out_value);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_silent(20, "reset_mid_load_silent");

    // Abort during output.
    build_expected(4);
    load_pattern(4);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 12) begin lat++; @(negedge clk); end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_out_setup: valid=%0b, required 1 before reset", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_value !== 40'd0) begin
      failures++;
      $display("FAIL reset_mid_out: valid=%0b value=%h, required 0/0", out_valid, out_value);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_silent(20, "reset_mid_out_silent");

    // Fresh pattern after reset.
    for (int k = 0; k < 16; k++) begin xm[k] = rnd16(); wm[k] = rnd16(); end
    run(2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_small_n2();
    test_identity_n4();
    test_extremes();
    test_random();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ss_matmul.md
Name: ss_matmul

Overview:
- Streaming square-matrix multiplier, single clock.
- Accepts two signed N×N matrices X and W on a 16-bit serial port, where N is 2 or 4.
- Returns the product C = X·W one element per cycle on a 40-bit port.
- Sits between the pattern/host stimulus interface and downstream checking logic; processes one pattern at a time.

Parameters:
- DATA_W, 16, element width of X and W (signed two's complement).
- OUT_W, 40, output width; C elements are sign-extended to this width.
- MAX_N, 4, largest supported matrix dimension.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  high while input elements are presented.
- matrix  input  16  current input element, signed, row-major: all of X, then all of W.
- matrix_size  input  1  sampled only on the first in_valid cycle; 0 → N=2, 1 → N=4.
- out_valid  output  1  high while out_value carries a result element.
- out_value  output  40  element of C, signed, row-major; 0 whenever out_valid is low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_value=0.
  - All storage, counters and the FSM return to IDLE.
  - Reset mid-input or mid-output aborts the pattern; no partial output follows.
- FSM states: IDLE → LOAD → CALC → OUT → IDLE.
- IDLE → LOAD:
  - Entered on the first cycle with in_valid=1.
  - That cycle latches matrix_size and stores the element as X[0][0].
- LOAD:
  - in_valid is held high for exactly 2·N² consecutive cycles: 8 for N=2, 32 for N=4.
  - Elements 0..N²−1 fill X[r][c] with r=k/N, c=k%N.
  - Elements N²..2N²−1 fill W the same way.
  - Leave LOAD when in_valid falls.
- CALC/OUT:
  - C[i][j] = Σ_{k<N} X[i][k]·W[k][j].
  - Full-precision signed arithmetic: 32-bit products, sum of at most 4 products fits in 34 bits; sign-extend to 40.
- Output timing:
  - First out_valid no earlier than 1 and no later than 10 cycles after the last in_valid cycle.
  - out_valid then stays high for exactly N² consecutive cycles: 4 or 16.
  - Order: C[0][0], C[0][1], …, C[N−1][N−1].
- Return to IDLE on the cycle after the last output; out_valid and out_value drop to 0 that cycle.
- in_valid and out_valid are never high in the same cycle.
- The bench waits at least 1 idle cycle after out_valid falls before the next pattern.
- Consecutive patterns may change N.
- matrix_size is ignored on all cycles except the first in_valid cycle.
- Unused upper storage (entries beyond 2×2 when N=2) must not affect results.
- Resources: implementation budget is at most 4 multipliers (one output element per cycle).

Test Plan:
- N=2, X=[1,2;3,4], W=[5,6;7,8] → out_valid 4 cycles, out_value 19,22,43,50.
- N=4, X=identity, W=row-major 1..16 → 16 outputs 1..16 in order; latency ≤ 10 cycles.
- N=2, X=W=[-32768,-32768;-32768,-32768] → each output 2147483648 (0x0080000000). Then X=[-1,2;0,1], W=[3,0;0,-4] → -3,-8,0,-4 sign-extended (0xFFFFFFFFFD, 0xFFFFFFFFF8, 0, 0xFFFFFFFFFC).
- N=4, all elements of X and W = -32768 → every output 4294967296 (0x0100000000).
- Back-to-back patterns N=4 then N=2 then N=4 with 1 idle cycle between → correct output counts 16/4/16. out_value is 0 on every cycle out_valid is low; out_valid never overlaps in_valid.
- Assert rst_n low in the middle of N=4 loading and again mid-output → outputs 0 immediately. The following fresh N=2 pattern produces correct results.
